// File: rtl/risc16_pc.sv
// RISC-16 program counter: sequential, PC-relative branch or absolute jump next-PC selection.
// Optional hold input enabled by defining PC_STALL_EN.
module risc16_pc #(
    parameter int unsigned      WIDTH        = 16,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PC_STALL_EN
    input  logic             stall,
`endif
    input  logic [1:0]       MUX_output,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] nxt_instr,
    output logic [WIDTH-1:0] pc_plus1
);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_RSVD   = 2'b11
    } pc_sel_e;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic             hold;

`ifdef PC_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign pc_plus1  = pc_q + WIDTH'(1);
    assign nxt_instr = pc_q;

    always_comb begin
        // NOTE: default first so every path assigns pc_d and no latch is inferred.
        pc_d = pc_plus1;
        if (!hold) begin
            unique case (pc_sel_e'(MUX_output))
                SEL_SEQ:    pc_d = pc_plus1;
                SEL_BRANCH: pc_d = pc_plus1 + imm;
                SEL_JUMP:   pc_d = alu_out;
                SEL_RSVD:   pc_d = pc_plus1;
                default:    pc_d = pc_plus1;
            endcase
        end else begin
            pc_d = pc_q;
        end
    end

    // NOTE: non-blocking assignment for registered state; reset overrides hold and select.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // An unknown select must be flagged rather than quietly treated as an increment.
    a_sel_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(MUX_output));

endmodule

// File: tb/tb_risc16_pc.sv
// Directed self-checking bench for risc16_pc; expected PCs queued at drive time, popped after each edge.
module tb_risc16_pc;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  MUX_output;
    logic [15:0] imm;
    logic [15:0] alu_out;
    logic [15:0] nxt_instr;
    logic [15:0] pc_plus1;

    typedef struct {
        string       tag;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    risc16_pc #(.WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef PC_STALL_EN
        .stall      (stall),
`endif
        .MUX_output (MUX_output),
        .imm        (imm),
        .alu_out    (alu_out),
        .nxt_instr  (nxt_instr),
        .pc_plus1   (pc_plus1)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, queue the expected PC, then compare one step after the edge.
    task automatic step(input string tag, input logic r, input logic s, input logic [1:0] sel,
                        input logic [15:0] im, input logic [15:0] alu, input logic [15:0] exp_pc);
        exp_t e;
        logic [15:0] exp_p1;
        rst        = r;
        stall      = s;
        MUX_output = sel;
        imm        = im;
        alu_out    = alu;
        e.tag = tag;
        e.pc  = exp_pc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        exp_p1 = e.pc + 16'd1;
        checks++;
        assert (nxt_instr === e.pc)
        else begin
            errors++;
            $error("FAIL %s nxt_instr: got %h expected %h", e.tag, nxt_instr, e.pc);
        end
        checks++;
        assert (pc_plus1 === exp_p1)
        else begin
            errors++;
            $error("FAIL %s pc_plus1: got %h expected %h", e.tag, pc_plus1, exp_p1);
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; MUX_output = 2'b00; imm = 16'h0000; alu_out = 16'h0000;

        step("reset",        1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        step("seq1",         1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0001);
        step("seq2",         1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0002);
        step("branch",       1'b0, 1'b0, 2'b01, 16'h000E, 16'hEEEE, 16'h0011);
        step("jump",         1'b0, 1'b0, 2'b10, 16'hEEEE, 16'hABCD, 16'hABCD);
        step("b2b_seq",      1'b0, 1'b0, 2'b00, 16'h1111, 16'h2222, 16'hABCE);
        step("b2b_jump",     1'b0, 1'b0, 2'b10, 16'h1111, 16'hBEEF, 16'hBEEF);
        step("b2b_branch",   1'b0, 1'b0, 2'b01, 16'h010F, 16'h3333, 16'hBFFF);
        step("reserved11",   1'b0, 1'b0, 2'b11, 16'h148A, 16'h000B, 16'hC000);
        step("jump_ffff",    1'b0, 1'b0, 2'b10, 16'h0000, 16'hFFFF, 16'hFFFF);
        step("wrap",         1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0000);
        step("jump_0005",    1'b0, 1'b0, 2'b10, 16'h0000, 16'h0005, 16'h0005);
        step("branch_m1",    1'b0, 1'b0, 2'b01, 16'hFFFF, 16'h0000, 16'h0005);
        step("jump_0005b",   1'b0, 1'b0, 2'b10, 16'h0000, 16'h0005, 16'h0005);
        step("branch_m2",    1'b0, 1'b0, 2'b01, 16'hFFFE, 16'h0000, 16'h0004);
        step("jump_1234",    1'b0, 1'b0, 2'b10, 16'h0000, 16'h1234, 16'h1234);
        step("rst_priority", 1'b1, 1'b1, 2'b10, 16'h0000, 16'h1234, 16'h0000);
        step("post_rst_seq", 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0001);
        step("branch_rst2",  1'b1, 1'b0, 2'b01, 16'h0100, 16'h0000, 16'h0000);
        step("post_rst2",    1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0001);
`ifdef PC_STALL_EN
        step("jump_0040",    1'b0, 1'b0, 2'b10, 16'h0000, 16'h0040, 16'h0040);
        step("stall_jump",   1'b0, 1'b1, 2'b10, 16'h0000, 16'h9999, 16'h0040);
        step("stall_branch", 1'b0, 1'b1, 2'b01, 16'h0010, 16'h0000, 16'h0040);
        step("stall_seq",    1'b0, 1'b1, 2'b00, 16'h0000, 16'h0000, 16'h0040);
        step("unstall_seq",  1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 16'h0041);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc16_pc.md
Name: risc16_pc

Overview:
Program counter for the 16-bit RISC-16 single-cycle core. It holds the address of the current instruction and updates it on every clock edge. The next address is one of: sequential (PC+1), PC-relative branch (PC+1+imm), or absolute jump (alu_out), selected by the control unit's next-PC mux select. Output feeds instruction memory address and the PC+1 link path.

Parameters:
WIDTH, 16, address/data width in bits
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
MUX_output  input  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 seq
imm  input  WIDTH  sign-extended branch offset, two's complement
alu_out  input  WIDTH  absolute jump target (JALR register value)
nxt_instr  output  WIDTH  registered current PC / instruction address
pc_plus1  output  WIDTH  combinational nxt_instr+1, for JALR link write-back
stall  input  1  present only with PC_STALL_EN; holds PC when high

Behaviour:
- Single register pc_q drives nxt_instr directly; no combinational path from inputs to nxt_instr.
- Every rising clk edge:
  - rst=1: pc_q <= RESET_VECTOR; overrides all other inputs, including stall and select.
  - else, select decode:
    - 00: pc_q <= pc_q+1
    - 01: pc_q <= pc_q+1+imm
    - 10: pc_q <= alu_out
    - 11: reserved; pc_q <= pc_q+1 (same as 00)
- Latency: new PC visible one cycle after select/operands are sampled.
- Arithmetic:
  - All sums modulo 2^WIDTH; carry discarded.
  - FFFF+1 wraps to 0000.
  - Negative imm (e.g. FFFF) moves PC backward; pc_q+1+FFFF equals pc_q.
- pc_plus1:
  - Always pc_q+1, modulo 2^WIDTH.
  - Combinational from pc_q only.
- Reset:
  - Reset mid-operation takes effect at the next edge regardless of select.
  - Released rst: first increment occurs on the following edge.
- X on MUX_output must not be silently masked in simulation. Decode with a full case plus a default that increments.

Optional Feature:
PC_STALL_EN
- Defined:
  - Adds the stall input port.
  - rst=0 and stall=1: pc_q holds its value, whatever MUX_output is.
  - rst still overrides stall.
- Undefined:
  - No stall port.
  - PC updates every cycle as above.

Test Plan:
- Reset: rst=1 for one edge from any PC -> nxt_instr=0000. Release, MUX_output=00, two edges -> 0001, then 0002.
- Branch: PC=0002, MUX_output=01, imm=000E, alu_out=EEEE -> 0011 after one edge.
- Jump: MUX_output=10, alu_out=ABCD, imm=EEEE -> ABCD after one edge, pc_plus1=ABCE.
- Back-to-back sequence:
  - Increment from ABCD -> ABCE.
  - Jump alu_out=BEEF -> BEEF.
  - Branch imm=010F -> BFFF.
  - Reserved 11 with imm=148A, alu_out=000B -> C000.
- Wrap/negative:
  - Jump to FFFF, then 00 -> 0000.
  - Branch imm=FFFF from 0005 -> 0005.
  - Branch imm=FFFE from 0005 -> 0004.
- Priority: rst=1 with MUX_output=10, alu_out=1234 (and stall=1 when PC_STALL_EN) -> 0000. With PC_STALL_EN, stall=1 for 3 edges at 0040 -> stays 0040.
